// File: rtl/opcode_sequencer.sv
// -----------------------------------------------------------------------------
// opcode_sequencer
//
// Program sequencer between a synchronous program ROM and an executor. Each
// step fetches one instruction word and issues it on OpCode. The word is held
// until the executor raises Done. OpCode then drops to 0 for at least one cycle
// before the next word is issued. An op nibble of 0 ends the program. Reaching
// the last address (PC all-ones) also ends the program, without wrapping.
//
// Optional build macro: SEQ_WATCHDOG_EN
//   defined   : an ISSUE-cycle watchdog aborts a stuck instruction after
//               TIMEOUT cycles and sets the sticky Error flag.
//   undefined : Error is tied 0 and ISSUE waits for Done indefinitely.
//
// Ports
//   Clock       in   system clock, rising edge
//   ResetN      in   synchronous active-low reset
//   Start       in   begin execution at StartAddr (sampled in IDLE only)
//   StartAddr   in   first instruction address
//   Abort       in   terminate program (wins over Start and Done)
//   ProgAddr    out  program store address (the PC register)
//   ProgData    in   program word, valid one cycle after ProgAddr changes
//   OpCode      out  instruction to executor, 0 when not issuing
//   Done        in   executor completion (level)
//   Busy        out  1 in every state except IDLE
//   Finished    out  1-cycle pulse on normal program end
//   Error       out  sticky watchdog flag
//   InstrCount  out  instructions completed since last Start, saturating
//   DbgState    out  current FSM state encoding
//
// Handshake: an instruction is issued when OpCode turns from 0 to non-zero.
// It is complete on the first rising edge where Done=1 while it is issued.
// After completion OpCode is 0. The next issue waits until Done has been seen
// low, so a level Done held over from the previous instruction never completes
// the next one.
// -----------------------------------------------------------------------------
module opcode_sequencer #(
  parameter int PC_WIDTH = 8,
  parameter int OP_WIDTH = 20,
  parameter int TIMEOUT  = 64
) (
  input  logic                Clock,
  input  logic                ResetN,
  input  logic                Start,
  input  logic [PC_WIDTH-1:0] StartAddr,
  input  logic                Abort,
  output logic [PC_WIDTH-1:0] ProgAddr,
  input  logic [OP_WIDTH-1:0] ProgData,
  output logic [OP_WIDTH-1:0] OpCode,
  input  logic                Done,
  output logic                Busy,
  output logic                Finished,
  output logic                Error,
  output logic [7:0]          InstrCount,
  output logic [2:0]          DbgState
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    ISSUE = 3'd3,
    GAP   = 3'd4
  } seqState_t;

  seqState_t           state, stateNext;
  logic [PC_WIDTH-1:0] pcQ, pcNext;
  logic [OP_WIDTH-1:0] opQ, opNext;
  logic [7:0]          countQ, countNext;
  logic                busyQ, busyNext;
  logic                finQ, finNext;

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdQ, wdNext;
  logic            errQ, errNext;
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT != 0);
`endif

  // Next-state and next-output logic.
  always_comb begin
    stateNext = state;
    pcNext    = pcQ;
    opNext    = opQ;
    countNext = countQ;
    finNext   = 1'b0;
`ifdef SEQ_WATCHDOG_EN
    wdNext    = wdQ;
    errNext   = errQ;
`endif
    if (state != IDLE && Abort) begin
      // Abort beats everything else. PC and InstrCount keep their values.
      stateNext = IDLE;
      opNext    = '0;
    end else begin
      case (state)
        IDLE: begin
          opNext = '0;
          if (Start && !Abort) begin
            stateNext = FETCH;
            pcNext    = StartAddr;
            countNext = '0;
`ifdef SEQ_WATCHDOG_EN
            errNext   = 1'b0;
`endif
          end
        end
        FETCH: stateNext = LOAD;  // one cycle of ROM latency
        LOAD: begin
          if (ProgData[OP_WIDTH-1 -: 4] == 4'd0) begin
            // End-of-program word: it is never issued.
            finNext   = 1'b1;
            stateNext = IDLE;
          end else begin
            opNext    = ProgData;
            stateNext = ISSUE;
`ifdef SEQ_WATCHDOG_EN
            wdNext    = '0;
`endif
          end
        end
        ISSUE: begin
          if (Done) begin
            opNext    = '0;
            stateNext = GAP;
            if (countQ != 8'hFF) countNext = countQ + 8'd1;
          end
`ifdef SEQ_WATCHDOG_EN
          else if (wdQ == WD_W'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th ISSUE cycle without Done.
            opNext    = '0;
            errNext   = 1'b1;
            stateNext = IDLE;
          end else begin
            wdNext = wdQ + WD_W'(1);
          end
`endif
        end
        GAP: begin
          opNext = '0;
          if (!Done) begin
            if (pcQ == '1) begin
              finNext   = 1'b1;  // last address executed; do not wrap
              stateNext = IDLE;
            end else begin
              pcNext    = pcQ + PC_WIDTH'(1);
              stateNext = FETCH;
            end
          end
        end
        default: begin
          stateNext = IDLE;
          opNext    = '0;
        end
      endcase
    end
    busyNext = (stateNext != IDLE);
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state  <= IDLE;
      pcQ    <= '0;
      opQ    <= '0;
      countQ <= '0;
      busyQ  <= 1'b0;
      finQ   <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wdQ    <= '0;
      errQ   <= 1'b0;
`endif
    end else begin
      state  <= stateNext;
      pcQ    <= pcNext;
      opQ    <= opNext;
      countQ <= countNext;
      busyQ  <= busyNext;
      finQ   <= finNext;
`ifdef SEQ_WATCHDOG_EN
      wdQ    <= wdNext;
      errQ   <= errNext;
`endif
    end
  end

  assign ProgAddr   = pcQ;
  assign OpCode     = opQ;
  assign Busy       = busyQ;
  assign Finished   = finQ;
  assign InstrCount = countQ;
  assign DbgState   = state;
`ifdef SEQ_WATCHDOG_EN
  assign Error      = errQ;
`else
  assign Error      = 1'b0;
`endif

endmodule

// File: tb/tb_opcode_sequencer.sv
module tb_opcode_sequencer;

  localparam int TB_TIMEOUT = 8;

  logic        Clock;
  logic        ResetN;
  logic        Start;
  logic [7:0]  StartAddr;
  logic        Abort;
  logic [7:0]  ProgAddr;
  logic [19:0] ProgData;
  logic [19:0] OpCode;
  logic        Done;
  logic        Busy;
  logic        Finished;
  logic        Error;
  logic [7:0]  InstrCount;
  logic [2:0]  DbgState;

  opcode_sequencer #(.PC_WIDTH(8), .OP_WIDTH(20), .TIMEOUT(TB_TIMEOUT)) dut (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .StartAddr(StartAddr),
    .Abort(Abort), .ProgAddr(ProgAddr), .ProgData(ProgData), .OpCode(OpCode),
    .Done(Done), .Busy(Busy), .Finished(Finished), .Error(Error),
    .InstrCount(InstrCount), .DbgState(DbgState)
  );

  // ---------------- clock ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- program ROM (synchronous read) ----------------
  logic [19:0] rom [256];
  always @(posedge Clock) ProgData <= rom[ProgAddr];

  // ---------------- scoreboard state ----------------
  logic [19:0] exp_q[$];
  int nChecks = 0;
  int nPass   = 0;
  int finCount = 0;
  int execDone = 0;
  int expRunLen = 0;   // 0 = issue length not checked
  int doneDelay = 2;
  int doneHold  = 1;
  bit execEn    = 1'b1;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- executor model ----------------
  // Raises Done on the doneDelay-th cycle an instruction is visible and holds
  // it for doneHold rising edges.
  initial begin
    int dcnt;
    int hcnt;
    dcnt = 0;
    hcnt = 0;
    Done = 1'b0;
    forever begin
      @(posedge Clock);
      #1;
      if (!execEn || !ResetN) begin
        Done = 1'b0; dcnt = 0; hcnt = 0;
      end else if (hcnt > 0) begin
        hcnt--;
        if (hcnt == 0) Done = 1'b0;
      end else if (OpCode != 20'h0) begin
        dcnt++;
        if (dcnt >= doneDelay) begin
          Done = 1'b1; hcnt = doneHold; dcnt = 0; execDone++;
        end
      end else begin
        dcnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [19:0] prevOp = '0;
  logic        prevFin = 1'b0;
  int          runLen = 0;
  always @(negedge Clock) begin
    if (Finished) begin
      finCount++;
      check_eq("finished_width", {31'd0, prevFin}, 32'd0);
    end
    if (OpCode != 20'h0) begin
      if (prevOp == 20'h0) begin
        runLen = 1;
        if (exp_q.size() == 0) check_eq("unexpected_issue", {12'd0, OpCode}, 32'd0);
        else check_eq("issue_word", {12'd0, OpCode}, {12'd0, exp_q.pop_front()});
      end else begin
        runLen++;
        check_eq("opcode_hold", {12'd0, OpCode}, {12'd0, prevOp});
      end
    end else if (prevOp != 20'h0 && expRunLen != 0) begin
      check_eq("issue_len", runLen, expRunLen);
    end
    prevOp  = OpCode;
    prevFin = Finished;
  end

  // ---------------- reference model ----------------
  // Walks the ROM the way the program runs: issue each non-zero-op word,
  // stop on an op-0 word or after the last address.
  task automatic model_prog(input int startA, output int cnt, output int lastPc, output int fin);
    int a;
    logic [19:0] w;
    a = startA; cnt = 0; fin = 0;
    while (1) begin
      w = rom[a];
      if (w[19:16] == 4'd0) begin fin = 1; break; end
      exp_q.push_back(w);
      cnt++;
      if (a == 255) begin fin = 1; break; end
      a++;
    end
    lastPc = a;
    if (cnt > 255) cnt = 255;
  endtask

  // ---------------- drivers ----------------
  task automatic do_start(input int a);
    @(negedge Clock);
    StartAddr = 8'(a);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    check_eq("busy_after_start", {31'd0, Busy}, 32'd1);
    check_eq("start_pc", {24'd0, ProgAddr}, a);
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (Busy && c < budget) begin
      @(negedge Clock);
      c++;
    end
    if (Busy) check_eq("idle_timeout", {31'd0, Busy}, 32'd0);
  endtask

  task automatic run_prog(input int startA, input int d, input int h);
    int expCnt, expPc, expFin, fin0, exec0, ex;
    model_prog(startA, expCnt, expPc, expFin);
    doneDelay = d; doneHold = h; expRunLen = d;
    fin0 = finCount; exec0 = execDone;
    do_start(startA);
    wait_idle(5000);
    @(negedge Clock);
    ex = execDone - exec0;
    if (ex > 255) ex = 255;
    check_eq("fin_count", finCount - fin0, expFin);
    check_eq("instr_count", {24'd0, InstrCount}, expCnt);
    check_eq("final_pc", {24'd0, ProgAddr}, expPc);
    check_eq("exp_q_empty", exp_q.size(), 0);
    check_eq("error_clear", {31'd0, Error}, 32'd0);
    check_eq("idle_opcode", {12'd0, OpCode}, 32'd0);
    check_eq("exec_vs_count", {24'd0, InstrCount}, ex);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_opcode"}, {12'd0, OpCode}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    check_eq({tag, "_finished"}, {31'd0, Finished}, 32'd0);
    check_eq({tag, "_error"}, {31'd0, Error}, 32'd0);
    check_eq({tag, "_count"}, {24'd0, InstrCount}, 32'd0);
    check_eq({tag, "_pc"}, {24'd0, ProgAddr}, 32'd0);
  endtask

  task automatic load_plan_rom();
    for (int i = 0; i < 256; i++) rom[i] = 20'h0;
    rom[0] = 20'h102AA;
    rom[1] = 20'h1014A;
    rom[2] = 20'h20102;
    rom[3] = 20'h00000;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c, fin0;
    ResetN = 1'b0; Start = 1'b0; Abort = 1'b0; StartAddr = 8'd0;
    load_plan_rom();
    repeat (3) @(negedge Clock);
    ResetN = 1'b1;
    check_reset_values("reset");

    // Directed program, short Done pulses.
    run_prog(0, 2, 1);

    // Start and Abort together in IDLE: Abort wins, nothing moves.
    @(negedge Clock);
    StartAddr = 8'd7; Start = 1'b1; Abort = 1'b1;
    @(negedge Clock);
    Start = 1'b0; Abort = 1'b0;
    check_eq("start_abort_busy", {31'd0, Busy}, 32'd0);
    check_eq("start_abort_pc", {24'd0, ProgAddr}, 32'd3);

    // Done held for 5 cycles: next issue waits for Done to fall.
    run_prog(0, 2, 5);

    // Last address: one issue then finish, no wrap.
    rom[255] = 20'h30101;
    run_prog(255, 2, 1);

    // Abort during the third instruction; a Start mid-program is ignored.
    expRunLen = 0; doneDelay = 3; doneHold = 1;
    exp_q.push_back(20'h102AA); exp_q.push_back(20'h1014A); exp_q.push_back(20'h20102);
    fin0 = finCount;
    do_start(0);
    @(negedge Clock);
    StartAddr = 8'd255; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    c = 0;
    while (OpCode != 20'h20102 && c < 200) begin @(negedge Clock); c++; end
    check_eq("abort_reached_third", {12'd0, OpCode}, 32'h20102);
    Abort = 1'b1;
    @(negedge Clock);
    Abort = 1'b0;
    check_eq("abort_opcode", {12'd0, OpCode}, 32'd0);
    check_eq("abort_busy", {31'd0, Busy}, 32'd0);
    @(negedge Clock);
    check_eq("abort_no_finish", finCount - fin0, 0);
    check_eq("abort_count", {24'd0, InstrCount}, 32'd2);
    check_eq("abort_pc", {24'd0, ProgAddr}, 32'd2);
    check_eq("abort_q_empty", exp_q.size(), 0);

    // Reset in the middle of an issued instruction.
    doneDelay = 4;
    exp_q.push_back(20'h102AA);
    do_start(0);
    c = 0;
    while (OpCode == 20'h0 && c < 50) begin @(negedge Clock); c++; end
    check_eq("reset_test_issued", {12'd0, OpCode}, 32'h102AA);
    ResetN = 1'b0;
    @(negedge Clock);
    ResetN = 1'b1;
    check_reset_values("midreset");
    exp_q.delete();
    run_prog(0, 1, 2);

    // Full address space, no end word: InstrCount saturates, PC stops at 255.
    for (int i = 0; i < 256; i++) rom[i] = {4'($urandom_range(1, 15)), 16'($urandom)};
    run_prog(0, 1, 1);

    // Randomized programs.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 256; i++)
        rom[i] = {($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15)), 16'($urandom)};
      run_prog($urandom_range(0, 255), $urandom_range(1, 4), $urandom_range(1, 5));
    end

`ifdef SEQ_WATCHDOG_EN
    // Executor never answers: watchdog fires after TB_TIMEOUT issue cycles.
    load_plan_rom();
    execEn = 1'b0;
    expRunLen = TB_TIMEOUT;
    exp_q.push_back(20'h102AA);
    fin0 = finCount;
    do_start(0);
    wait_idle(500);
    @(negedge Clock);
    check_eq("wd_error", {31'd0, Error}, 32'd1);
    check_eq("wd_opcode", {12'd0, OpCode}, 32'd0);
    check_eq("wd_no_finish", finCount - fin0, 0);
    check_eq("wd_count", {24'd0, InstrCount}, 32'd0);
    execEn = 1'b1;
    run_prog(0, 2, 1);  // next Start clears Error
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
